// File: rtl/inst_fifo_param_if.sv
// IF -> queue -> ID bus bundle: fetch push side, decode pop side, and status.
interface inst_fifo_param_if #(
    parameter int unsigned DEPTH_LOG = 4,
    parameter int unsigned INST_W    = 32,
    parameter int unsigned ADDR_W    = 32
);
    // Fetch side
    logic                 if_valid;
    logic [INST_W-1:0]    if_inst;
    logic [ADDR_W-1:0]    if_pc;
    logic                 almost_full;
    logic                 overflow;

    // Decode side
    logic                 id_ready;
    logic                 id_valid;
    logic [INST_W-1:0]    id_inst;
    logic [ADDR_W-1:0]    id_pc;

    // Occupancy: storage entries plus the head output register
    logic [DEPTH_LOG:0]   count;

    // Producer/consumer environment around the queue
    modport master (
        output if_valid, if_inst, if_pc, id_ready,
        input  almost_full, overflow, id_valid, id_inst, id_pc, count
    );

    // The queue itself
    modport slave (
        input  if_valid, if_inst, if_pc, id_ready,
        output almost_full, overflow, id_valid, id_inst, id_pc, count
    );
endinterface

// File: rtl/inst_fifo_param.sv
// Parametrised IF->ID instruction queue: circular store behind a registered
// head stage, empty-queue bypass, flush, registered almost-full, sticky overflow.
module inst_fifo_param #(
    parameter int unsigned DEPTH_LOG = 4,
    parameter int unsigned INST_W    = 32,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned AF_MARGIN = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 flush,
    inst_fifo_param_if.slave     bus
);
    localparam int unsigned DEPTH    = 1 << DEPTH_LOG;
    localparam int unsigned CNT_W    = DEPTH_LOG + 1;
    localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

    // Storage array (no reset: contents are only read behind scount)
    logic [INST_W-1:0]    mem_inst [DEPTH];
    logic [ADDR_W-1:0]    mem_pc   [DEPTH];

    // Registered state
    logic [DEPTH_LOG-1:0] head_q, tail_q;
    logic [CNT_W-1:0]     scount_q;
    logic                 id_valid_q;
    logic [INST_W-1:0]    id_inst_q;
    logic [ADDR_W-1:0]    id_pc_q;
    logic                 af_q;
    logic                 ovf_q;

    // Next-state values
    logic [DEPTH_LOG-1:0] head_n, tail_n;
    logic [CNT_W-1:0]     scount_n;
    logic                 id_valid_n;
    logic [INST_W-1:0]    id_inst_n;
    logic [ADDR_W-1:0]    id_pc_n;
    logic                 af_n;
    logic                 ovf_n;

    // Per-cycle handshake decode
    logic                 pop;
    logic                 has_space;
    logic                 push;
    logic                 wr_en;
    logic                 mv_en;

    // A push is accepted when storage has room or a pop frees the head stage
    assign pop       = id_valid_q & bus.id_ready;
    assign has_space = scount_q < CNT_W'(DEPTH);
    assign push      = bus.if_valid & (has_space | pop);

    // Next-state decode: hold when !rdy, clear on flush, else move data
    always_comb begin
        head_n     = head_q;
        tail_n     = tail_q;
        scount_n   = scount_q;
        id_valid_n = id_valid_q;
        id_inst_n  = id_inst_q;
        id_pc_n    = id_pc_q;
        af_n       = af_q;
        ovf_n      = ovf_q;
        wr_en      = 1'b0;
        mv_en      = 1'b0;

        if (rdy) begin
            if (flush) begin
                head_n     = '0;
                tail_n     = '0;
                scount_n   = '0;
                id_valid_n = 1'b0;
                af_n       = 1'b0;
                ovf_n      = 1'b0;
            end else begin
                if (bus.if_valid && !push) begin
                    ovf_n = 1'b1;
                end

                if (pop && (scount_q != '0)) begin
                    // Oldest stored entry advances into the head stage;
                    // a concurrent push lands at tail, even when full.
                    id_inst_n = mem_inst[head_q];
                    id_pc_n   = mem_pc[head_q];
                    head_n    = head_q + DEPTH_LOG'(1);
                    mv_en     = 1'b1;
                    wr_en     = push;
                end else if (pop && push) begin
                    // Storage empty: streaming pass-through, no bubble
                    id_inst_n = bus.if_inst;
                    id_pc_n   = bus.if_pc;
                end else if (pop) begin
                    id_valid_n = 1'b0;
                end else if (!id_valid_q && push) begin
                    // Empty queue: bypass storage straight into the head stage
                    id_valid_n = 1'b1;
                    id_inst_n  = bus.if_inst;
                    id_pc_n    = bus.if_pc;
                end else if (push) begin
                    wr_en = 1'b1;
                end

                if (wr_en) begin
                    tail_n = tail_q + DEPTH_LOG'(1);
                end

                scount_n = scount_q + CNT_W'(wr_en) - CNT_W'(mv_en);
                af_n     = scount_n >= CNT_W'(AF_LEVEL);
            end
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            scount_q   <= '0;
            id_valid_q <= 1'b0;
            id_inst_q  <= '0;
            id_pc_q    <= '0;
            af_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            head_q     <= head_n;
            tail_q     <= tail_n;
            scount_q   <= scount_n;
            id_valid_q <= id_valid_n;
            id_inst_q  <= id_inst_n;
            id_pc_q    <= id_pc_n;
            af_q       <= af_n;
            ovf_q      <= ovf_n;
        end
    end

    // Storage write port at tail
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            mem_inst[tail_q] <= bus.if_inst;
            mem_pc[tail_q]   <= bus.if_pc;
        end
    end

    assign bus.id_valid    = id_valid_q;
    assign bus.id_inst     = id_inst_q;
    assign bus.id_pc       = id_pc_q;
    assign bus.almost_full = af_q;
    assign bus.overflow    = ovf_q;
    assign bus.count       = scount_q + CNT_W'(id_valid_q);

    // Storage may only hold entries while the head stage is occupied
    a_empty_head_implies_empty_store: assert property (
        @(posedge clk) disable iff (rst) (!id_valid_q |-> (scount_q == '0))
    );
endmodule
